// File: rtl/test_seq_pkg.sv
// ----------------------------------------------------------------------------
// test_seq_pkg
//   Shared types for the reset/test sequencer.
//   state_e  : sequencer FSM states.
//   status_e : encoding of the 2-bit status output
//              (NONE=0, PASS=1, FAIL=2, TIMEOUT=3).
//   is_terminal() : true for the three end-of-test states.
// ----------------------------------------------------------------------------
package test_seq_pkg;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    RELEASE = 3'd1,
    RUN     = 3'd2,
    PASS    = 3'd3,
    FAIL    = 3'd4,
    TIMEOUT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    STATUS_NONE    = 2'd0,
    STATUS_PASS    = 2'd1,
    STATUS_FAIL    = 2'd2,
    STATUS_TIMEOUT = 2'd3
  } status_e;

  localparam int STATUS_W = 2;

  function automatic logic is_terminal(input state_e s);
    return (s == PASS) || (s == FAIL) || (s == TIMEOUT);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// ----------------------------------------------------------------------------
// reset_sync
//   Reset synchronizer: assertion is asynchronous, deassertion is taken
//   through SYNC_STAGES flops so the released reset is clean in the clock
//   domain. The output deasserts after the SYNC_STAGES-th rising edge that
//   follows reset_n rising.
// Ports
//   clock        in  1  clock
//   reset_n      in  1  asynchronous active-low reset from the board
//   sync_reset_n out 1  active-low reset, synchronously deasserted
// ----------------------------------------------------------------------------
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  output logic sync_reset_n
);

  logic [SYNC_STAGES-1:0] sync_ff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_reset_n = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/reset_test_sequencer.sv
// ----------------------------------------------------------------------------
// reset_test_sequencer
//   Test-harness controller. After the board reset is released (and
//   synchronized) all DUT channel resets are held for RESET_CYCLES cycles,
//   then released one by one STAGGER_CYCLES apart. Once the last channel is
//   out of reset the sequencer runs a watchdog cycle counter and reports
//   PASS / FAIL / TIMEOUT from the DUT's done/fail levels. A restart pulse
//   re-runs the sequence from HOLD without a board reset.
//
// Parameters
//   NUM_CHANNELS   number of DUT reset outputs (>=1)
//   RESET_CYCLES   cycles all channels are held after the reset sync (>=1)
//   STAGGER_CYCLES cycles between channel releases (0 = all together)
//   TIMEOUT_CYCLES RUN cycles before TIMEOUT (>=1)
//   SYNC_STAGES    synchronizer depth (>=2)
//   CYC_W          derived width of cycle_count
//
// Ports
//   clock       in   1             clock
//   reset       in   1             async active-low board reset
//   restart     in   1             pulse: re-run the sequence from HOLD
//   dut_done    in   1             DUT completion level (used in RUN only)
//   dut_fail    in   1             DUT failure level (used in RUN only)
//   chan_reset  out  NUM_CHANNELS  active-high DUT resets, registered
//   running     out  1             high while in RUN
//   finished    out  1             high in PASS/FAIL/TIMEOUT
//   status      out  2             test_seq_pkg::status_e
//   cycle_count out  CYC_W         RUN cycles elapsed, saturating
//
// Build option
//   TEST_SEQ_SIM_FINISH_EN : simulation-only; on reaching a terminal state
//   the result is printed and the simulation finishes one cycle later.
//   Restart is ignored once finished in that build. Leave undefined for
//   FPGA builds, where terminal states persist until restart or reset.
// ----------------------------------------------------------------------------
module reset_test_sequencer
  import test_seq_pkg::*;
#(
  parameter  int NUM_CHANNELS   = 3,
  parameter  int RESET_CYCLES   = 10,
  parameter  int STAGGER_CYCLES = 4,
  parameter  int TIMEOUT_CYCLES = 10000,
  parameter  int SYNC_STAGES    = 2,
  localparam int CYC_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    restart,
  input  logic                    dut_done,
  input  logic                    dut_fail,
  output logic [NUM_CHANNELS-1:0] chan_reset,
  output logic                    running,
  output logic                    finished,
  output logic [1:0]              status,
  output logic [CYC_W-1:0]        cycle_count
);

  // Shared hold/stagger counter only ever counts to max(RESET, STAGGER)-1.
  localparam int CNT_MAX = (RESET_CYCLES > STAGGER_CYCLES) ? RESET_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  // With a single channel or no stagger there is nothing to release in
  // steps, so HOLD hands over straight to RUN.
  localparam bit DIRECT_RUN = (NUM_CHANNELS == 1) || (STAGGER_CYCLES == 0);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [CYC_W-1:0] TO_LAST   = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYC_W-1:0] TO_MAX    = CYC_W'(TIMEOUT_CYCLES);

  logic             rst_sync_n;
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             restart_eff;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] c);
    if (c >= TO_MAX) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clock        (clock),
    .reset_n      (reset),
    .sync_reset_n (rst_sync_n)
  );

`ifdef TEST_SEQ_SIM_FINISH_EN
  assign restart_eff = restart & ~finished;
`else
  assign restart_eff = restart;
`endif

  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      chan_reset  <= '1;
      running     <= 1'b0;
      finished    <= 1'b0;
      status      <= STATUS_NONE;
      cycle_count <= '0;
    end else if (restart_eff) begin
      // Restart from anywhere (HOLD included) re-arms the whole sequence;
      // the synchronizer is not involved, so HOLD starts counting next edge.
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      chan_reset  <= '1;
      running     <= 1'b0;
      finished    <= 1'b0;
      status      <= STATUS_NONE;
      cycle_count <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (DIRECT_RUN) begin
              chan_reset <= '0;
              running    <= 1'b1;
              state      <= RUN;
            end else begin
              // Channels release LSB first, so each release is a left shift.
              chan_reset <= chan_reset << 1;
              idx        <= IDX_W'(1);
              state      <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RELEASE: begin
          if (cnt == STAG_LAST) begin
            cnt        <= '0;
            chan_reset <= chan_reset << 1;
            if (idx == LAST_IDX) begin
              running <= 1'b1;
              state   <= RUN;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          // The sampling edge also counts as a RUN cycle.
          cycle_count <= sat_inc(cycle_count);
          if (dut_fail) begin
            state    <= FAIL;
            status   <= STATUS_FAIL;
            running  <= 1'b0;
            finished <= 1'b1;
          end else if (dut_done) begin
            state    <= PASS;
            status   <= STATUS_PASS;
            running  <= 1'b0;
            finished <= 1'b1;
          end else if (cycle_count == TO_LAST) begin
            state    <= TIMEOUT;
            status   <= STATUS_TIMEOUT;
            running  <= 1'b0;
            finished <= 1'b1;
          end
        end

        default: begin
          // Terminal states hold everything until restart or reset.
        end
      endcase
    end
  end

`ifdef TEST_SEQ_SIM_FINISH_EN
  logic finish_pending;

  always_ff @(posedge clock or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      finish_pending <= 1'b0;
    end else begin
      if (finish_pending) begin
        $finish;
      end
      if (finished && !finish_pending) begin
        $display("reset_test_sequencer: status=%0d cycle_count=%0d", status, cycle_count);
        finish_pending <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reset_test_sequencer.sv
// ----------------------------------------------------------------------------
// tb_reset_test_sequencer
//   Self-checking bench for reset_test_sequencer with NUM_CHANNELS=3,
//   RESET_CYCLES=10, STAGGER_CYCLES=4, TIMEOUT_CYCLES=20, SYNC_STAGES=2.
//   Expected outputs come from a timeline model: edges counted from the
//   sequence start, channel i free from RESET + i*STAGGER, RUN from the last
//   release, then a terminal result chosen by the stimulus.
// ----------------------------------------------------------------------------
module tb_reset_test_sequencer;

  localparam int N     = 3;
  localparam int RC    = 10;
  localparam int SC    = 4;
  localparam int TO    = 20;
  localparam int SS    = 2;
  localparam int RUN_J = RC + (N - 1) * SC;

  // Scenario kinds for the RUN phase
  localparam int K_TIMEOUT = 0;
  localparam int K_DONE    = 1;
  localparam int K_FAIL    = 2;
  localparam int K_BOTH    = 3;
  localparam int K_RESTART = 4;

  logic         clock   = 1'b0;
  logic         clk_en  = 1'b1;
  logic         reset   = 1'b1;
  logic         restart = 1'b0;
  logic         dut_done = 1'b0;
  logic         dut_fail = 1'b0;
  logic [N-1:0] chan_reset;
  logic         running;
  logic         finished;
  logic [1:0]   status;
  logic [4:0]   cycle_count;

  int errors = 0;
  int checks = 0;

  reset_test_sequencer #(
    .NUM_CHANNELS   (N),
    .RESET_CYCLES   (RC),
    .STAGGER_CYCLES (SC),
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (SS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .restart     (restart),
    .dut_done    (dut_done),
    .dut_fail    (dut_fail),
    .chan_reset  (chan_reset),
    .running     (running),
    .finished    (finished),
    .status      (status),
    .cycle_count (cycle_count)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clock = ~clock;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Channel reset pattern j edges into a sequence (j<=0: all held).
  function automatic logic [N-1:0] exp_chan(input int j);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (j < RC + i * SC);
    return r;
  endfunction

  function automatic logic [11:0] obs();
    return {chan_reset, running, finished, status, cycle_count};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Board reset pulse; afterwards the next two edges are synchronizer edges
  // (j = -1, 0) and HOLD counting begins at j = 1.
  task automatic board_reset();
    logic [11:0] e;
    @(negedge clock);
    reset = 1'b0;
    #1;
    e = {3'b111, 1'b0, 1'b0, 2'd0, 5'd0};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL async_reset_assert: got %b required %b", obs(), e);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Edges from_j..to_j of the reset/release phase.
  task automatic release_phase(input string tag, input int from_j, input int to_j);
    logic [11:0] e;
    for (int j = from_j; j <= to_j; j++) begin
      tick();
      e = {exp_chan(j), (j >= RUN_J), 1'b0, 2'd0, 5'd0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s j=%0d: got %b required %b", tag, j, obs(), e);
      end
    end
  endtask

  task automatic restart_pulse(input string tag);
    logic [11:0] e;
    @(negedge clock);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    e = {3'b111, 1'b0, 1'b0, 2'd0, 5'd0};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL %s restart_edge: got %b required %b", tag, obs(), e);
    end
  endtask

  // RUN phase from cycle_count=0. At count stop_k the chosen event is
  // applied; afterwards random done/fail must have no effect.
  task automatic run_phase(input string tag, input int stop_k, input int kind);
    logic [11:0] e;
    logic [11:0] held;
    bit          term;
    term = 1'b0;
    held = '0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clock);
      if (k == stop_k) begin
        dut_done = (kind == K_DONE) || (kind == K_BOTH);
        dut_fail = (kind == K_FAIL) || (kind == K_BOTH);
        restart  = (kind == K_RESTART);
      end
      tick();
      dut_done = 1'b0;
      dut_fail = 1'b0;
      restart  = 1'b0;
      if (k == stop_k && kind == K_RESTART) begin
        e = {3'b111, 1'b0, 1'b0, 2'd0, 5'd0};
        term = 1'b1;
      end else if (k == stop_k && kind != K_TIMEOUT) begin
        e = {3'b000, 1'b0, 1'b1, (kind == K_DONE) ? 2'd1 : 2'd2, 5'(k + 1)};
        term = 1'b1;
      end else if (k == TO - 1) begin
        e = {3'b000, 1'b0, 1'b1, 2'd3, 5'(TO)};
        term = 1'b1;
      end else begin
        e = {3'b000, 1'b1, 1'b0, 2'd0, 5'(k + 1)};
      end
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s run k=%0d: got %b required %b", tag, k, obs(), e);
      end
      held = e;
      if (term) break;
    end
    if (kind != K_RESTART) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        dut_done = 1'($urandom_range(0, 1));
        dut_fail = 1'($urandom_range(0, 1));
        tick();
        checks++;
        if (obs() !== held) begin
          errors++;
          $display("FAIL %s terminal_hold c=%0d: got %b required %b", tag, c, obs(), held);
        end
      end
      @(negedge clock);
      dut_done = 1'b0;
      dut_fail = 1'b0;
    end
  endtask

  task automatic test_reset();
    board_reset();
    release_phase("reset_sync", -1, 0);
  endtask

  task automatic test_timeout();
    release_phase("seq_timeout", 1, RUN_J);
    run_phase("timeout", -1, K_TIMEOUT);
  endtask

  task automatic test_done();
    int k;
    restart_pulse("done5");
    release_phase("done5", 1, RUN_J);
    run_phase("done5", 5, K_DONE);
    for (int it = 0; it < 3; it++) begin
      k = int'($urandom_range(0, TO - 2));
      restart_pulse("done_rand");
      release_phase("done_rand", 1, RUN_J);
      run_phase("done_rand", k, K_DONE);
    end
  endtask

  task automatic test_done_on_timeout_edge();
    restart_pulse("done_last");
    release_phase("done_last", 1, RUN_J);
    run_phase("done_last", TO - 1, K_DONE);
  endtask

  task automatic test_fail();
    restart_pulse("both");
    release_phase("both", 1, RUN_J);
    run_phase("both", int'($urandom_range(0, TO - 1)), K_BOTH);
    restart_pulse("fail");
    release_phase("fail", 1, RUN_J);
    run_phase("fail", int'($urandom_range(0, TO - 1)), K_FAIL);
  endtask

  task automatic test_restart_states();
    restart_pulse("rs_hold");
    release_phase("rs_hold", 1, 5);
    restart_pulse("rs_hold2");
    release_phase("rs_hold2", 1, 14);
    restart_pulse("rs_release");
    release_phase("rs_release", 1, RUN_J);
    run_phase("rs_run", int'($urandom_range(0, TO - 1)), K_RESTART);
    release_phase("rs_after_run", 1, RUN_J);
    run_phase("rs_after_run", 3, K_DONE);
  endtask

  // Board reset with the clock stopped, first from PASS, then mid-RELEASE.
  task automatic test_reset_clock_stopped();
    logic [11:0] e;
    e = {3'b111, 1'b0, 1'b0, 2'd0, 5'd0};
    @(negedge clock);
    clk_en = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL stopped_reset_pass: got %b required %b", obs(), e);
    end
    #20;
    reset = 1'b1;
    #20;
    clk_en = 1'b1;
    release_phase("stopped_pass_seq", -1, 14);
    // chan_reset is now 100 (mid-RELEASE)
    @(negedge clock);
    clk_en = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL stopped_reset_release: got %b required %b", obs(), e);
    end
    #20;
    reset = 1'b1;
    #20;
    clk_en = 1'b1;
    release_phase("stopped_rel_seq", -1, RUN_J);
    run_phase("stopped_rel_seq", -1, K_TIMEOUT);
  endtask

  initial begin
    // Let the design clock a few cycles before the board reset arrives.
    repeat (3) @(posedge clock);
    test_reset();
    test_timeout();
    test_done();
    test_done_on_timeout_edge();
    test_fail();
    test_restart_states();
    test_reset_clock_stopped();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
